// File: rtl/line_buffer_3row.sv
// -----------------------------------------------------------------------------
// line_buffer_3row
//
// Raster-to-column line buffer feeding a 3x3 median stage. Pixels arrive one
// per accepted cycle in raster order. Two line memories keep the previous row
// (la_mem) and the row before that (lb_mem). For every accepted pixel the
// vertically aligned column (two rows back, one row back, current) is emitted
// one cycle later. Columns are emitted only from image row 2 onward.
//
// Parameters:
//   WIDTH  pixels per line (2..4096)
//   COL_W  column index width, derived from WIDTH
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   pixel qualifier
//   in_sof     start of frame (row 0, col 0), sampled with in_valid
//   in_pixel   8-bit pixel
//   out_valid  column qualifier (registered, 1-cycle latency)
//   out_top    pixel two rows back, same column
//   out_mid    pixel one row back, same column
//   out_bot    current pixel
//   out_col    column index of emitted column
//   out_eol    emitted column is the last column of the line
// -----------------------------------------------------------------------------
module line_buffer_3row #(
  parameter int WIDTH = 100,
  parameter int COL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [7:0]       in_pixel,
  output logic             out_valid,
  output logic [7:0]       out_top,
  output logic [7:0]       out_mid,
  output logic [7:0]       out_bot,
  output logic [COL_W-1:0] out_col,
  output logic             out_eol
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ONE    = 2'd1,
    PRIMED = 2'd2
  } rows_t;

  rows_t            rows_reg, rows_next, rows_eff;
  logic [COL_W-1:0] col_reg, col_next, col_eff;
  logic             wrap;
  logic             emit;
  logic             accept;

  logic             out_valid_reg;
  logic             out_eol_reg;
  logic [7:0]       out_bot_reg;
  logic [COL_W-1:0] out_col_reg;
  logic             data_ok_reg;

  // Registered memory read data (read-first: values from before this write).
  logic [7:0]       top_q;
  logic [7:0]       mid_q;

  logic [7:0]       la_mem [0:WIDTH-1];
  logic [7:0]       lb_mem [0:WIDTH-1];

  // Memory writes must not happen while reset is held: the pixel is dropped.
  assign accept = in_valid & ~rst;

  // Next-state logic. A start-of-frame pixel is processed as if col and rows
  // had already been forced to 0/EMPTY, so it lands at row 0, column 0.
  always_comb begin
    col_eff   = col_reg;
    rows_eff  = rows_reg;
    col_next  = col_reg;
    rows_next = rows_reg;
    wrap      = 1'b0;
    emit      = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        col_eff  = '0;
        rows_eff = EMPTY;
      end
      wrap      = (col_eff == LAST_COL);
      emit      = (rows_eff == PRIMED);
      col_next  = wrap ? '0 : col_eff + COL_W'(1);
      rows_next = rows_eff;
      if (wrap) begin
        case (rows_eff)
          EMPTY:   rows_next = ONE;
          ONE:     rows_next = PRIMED;
          default: rows_next = PRIMED;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_reg      <= EMPTY;
      col_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_eol_reg   <= 1'b0;
      out_bot_reg   <= '0;
      out_col_reg   <= '0;
      data_ok_reg   <= 1'b0;
    end else begin
      rows_reg      <= rows_next;
      col_reg       <= col_next;
      out_valid_reg <= emit;
      out_eol_reg   <= emit & wrap;
      if (in_valid) begin
        out_bot_reg <= in_pixel;
        out_col_reg <= col_eff;
        data_ok_reg <= 1'b1;
      end
    end
  end

  // Line memories: no reset, contents before priming are never emitted.
  // LB takes the old LA value, so LB always holds the row before LA.
  always_ff @(posedge clk) begin
    if (accept) begin
      mid_q           <= la_mem[col_eff];
      top_q           <= lb_mem[col_eff];
      lb_mem[col_eff] <= la_mem[col_eff];
      la_mem[col_eff] <= in_pixel;
    end
  end

  // The read registers cannot be reset; data_ok_reg forces the outputs to 0
  // from reset until the first pixel has been read through them.
  assign out_valid = out_valid_reg;
  assign out_eol   = out_eol_reg;
  assign out_bot   = out_bot_reg;
  assign out_col   = out_col_reg;
  assign out_top   = data_ok_reg ? top_q : 8'h00;
  assign out_mid   = data_ok_reg ? mid_q : 8'h00;

endmodule

// File: tb/tb_line_buffer_3row.sv
// -----------------------------------------------------------------------------
// tb_line_buffer_3row
//
// Drives a WIDTH=4 and a WIDTH=2 instance with the same pixel stream and
// checks both against a frame-history model: the n-th pixel of the current
// frame sits at row n/W, column n%W, and its column is emitted when n >= 2W
// with top = pixel n-2W and mid = pixel n-W.
// -----------------------------------------------------------------------------
module tb_line_buffer_3row;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_pixel;

  logic       a_valid, a_eol;
  logic [7:0] a_top, a_mid, a_bot;
  logic [1:0] a_col;
  logic       b_valid, b_eol;
  logic [7:0] b_top, b_mid, b_bot;
  logic [0:0] b_col;

  always #5 clk = ~clk;

  line_buffer_3row #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .in_pixel(in_pixel), .out_valid(a_valid), .out_top(a_top),
    .out_mid(a_mid), .out_bot(a_bot), .out_col(a_col), .out_eol(a_eol)
  );

  line_buffer_3row #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .in_pixel(in_pixel), .out_valid(b_valid), .out_top(b_top),
    .out_mid(b_mid), .out_bot(b_bot), .out_col(b_col), .out_eol(b_eol)
  );

  // Observed outputs gathered per instance (k=0: WIDTH 4, k=1: WIDTH 2).
  logic       ov [2];
  logic       oe [2];
  logic [7:0] ot [2];
  logic [7:0] om [2];
  logic [7:0] ob [2];
  int         oc [2];

  always_comb begin
    ov[0] = a_valid; oe[0] = a_eol; ot[0] = a_top; om[0] = a_mid;
    ob[0] = a_bot;   oc[0] = int'(a_col);
    ov[1] = b_valid; oe[1] = b_eol; ot[1] = b_top; om[1] = b_mid;
    ob[1] = b_bot;   oc[1] = int'(b_col);
  end

  // Reference model state.
  int         wid   [2] = '{4, 2};
  int         n_pix [2];
  logic [7:0] hist  [2][0:1023];
  logic       ev    [2];
  logic       ee    [2];
  logic [7:0] et    [2];
  logic [7:0] em    [2];
  logic [7:0] eb    [2];
  int         ec    [2];
  logic       known [2];

  int tests = 0;
  int fails = 0;
  logic [31:0] seq_cont[$];
  logic [31:0] seq_gap[$];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      n_pix[k] = 0;
      ev[k] = 1'b0; ee[k] = 1'b0;
      et[k] = 8'h00; em[k] = 8'h00; eb[k] = 8'h00; ec[k] = 0;
      known[k] = 1'b1;
    end
  endtask

  task automatic model_step(input logic v, input logic s, input logic [7:0] p);
    for (int k = 0; k < 2; k++) begin
      if (v) begin
        if (s) n_pix[k] = 0;
        ev[k] = (n_pix[k] >= 2 * wid[k]);
        if (ev[k]) begin
          et[k] = hist[k][n_pix[k] - 2 * wid[k]];
          em[k] = hist[k][n_pix[k] - wid[k]];
          eb[k] = p;
          ec[k] = n_pix[k] % wid[k];
        end
        known[k] = ev[k];
        ee[k] = ev[k] && (ec[k] == wid[k] - 1);
        if (n_pix[k] < 1024) hist[k][n_pix[k]] = p;
        n_pix[k]++;
      end else begin
        ev[k] = 1'b0;
        ee[k] = 1'b0;
      end
    end
  endtask

  // One clock of stimulus; outputs are stable at return (#1 after the edge).
  task automatic cyc(input logic v, input logic s, input logic [7:0] p);
    @(negedge clk);
    in_valid = v; in_sof = s; in_pixel = p;
    model_step(v, s, p);
    @(posedge clk);
    #1;
    $display("[TB] t=%0t v=%0d sof=%0d pix=%02h | w4 v=%0d t=%02h m=%02h b=%02h c=%0d e=%0d | w2 v=%0d c=%0d e=%0d",
             $time, v, s, p, a_valid, a_top, a_mid, a_bot, a_col, a_eol, b_valid, b_col, b_eol);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({ov[k], oe[k], ot[k], om[k], ob[k]} !== 27'd0 || oc[k] != 0) begin
        fails++;
        $display("FAIL reset_outputs w%0d got v=%b e=%b t=%02h m=%02h b=%02h c=%0d want all 0",
                 wid[k], ov[k], oe[k], ot[k], om[k], ob[k], oc[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_continuous();
    int nv = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        cyc(1'b1, (r == 0 && c == 0), 8'(r * 16 + c));
        for (int k = 0; k < 2; k++) begin
          tests++;
          if ({ov[k], oe[k]} !== {ev[k], ee[k]}) begin
            fails++;
            $display("FAIL cont_valid_eol w%0d got %b%b want %b%b", wid[k], ov[k], oe[k], ev[k], ee[k]);
          end
          if (known[k]) begin
            tests++;
            if ({ot[k], om[k], ob[k]} !== {et[k], em[k], eb[k]} || oc[k] != ec[k]) begin
              fails++;
              $display("FAIL cont_column w%0d got %02h %02h %02h c%0d want %02h %02h %02h c%0d",
                       wid[k], ot[k], om[k], ob[k], oc[k], et[k], em[k], eb[k], ec[k]);
            end
          end
        end
        if (a_valid) begin
          nv++;
          seq_cont.push_back({a_top, a_mid, a_bot, 6'd0, a_col});
        end
        if (r == 2 && c == 0) begin
          tests++;
          if ({a_valid, a_top, a_mid, a_bot, a_col, a_eol} !== {1'b1, 8'h00, 8'h10, 8'h20, 2'd0, 1'b0}) begin
            fails++;
            $display("FAIL first_col got v=%b %02h %02h %02h c%0d e=%b want 1 00 10 20 c0 e0",
                     a_valid, a_top, a_mid, a_bot, a_col, a_eol);
          end
        end
        if (r == 2 && c == 3) begin
          tests++;
          if ({a_valid, a_top, a_mid, a_bot, a_eol} !== {1'b1, 8'h03, 8'h13, 8'h23, 1'b1}) begin
            fails++;
            $display("FAIL eol_col got v=%b %02h %02h %02h e=%b want 1 03 13 23 e1",
                     a_valid, a_top, a_mid, a_bot, a_eol);
          end
        end
        if (r == 4 && c == 1) begin
          tests++;
          if ({a_valid, a_top, a_mid, a_bot} !== {1'b1, 8'h21, 8'h31, 8'h41}) begin
            fails++;
            $display("FAIL row4_col got v=%b %02h %02h %02h want 1 21 31 41",
                     a_valid, a_top, a_mid, a_bot);
          end
        end
      end
    end
    cyc(1'b0, 1'b0, 8'h00);
    tests++;
    if (nv != 12 || a_valid !== 1'b0) begin
      fails++;
      $display("FAIL cont_valid_count got %0d (trail v=%b) want 12 (trail v=0)", nv, a_valid);
    end
  endtask

  task automatic test_gaps();
    int idx = 0;
    while (idx < 20) begin
      if ($urandom_range(0, 1) == 0) begin
        cyc(1'b0, 1'b0, 8'($urandom));
      end else begin
        cyc(1'b1, (idx == 0), 8'((idx / 4) * 16 + (idx % 4)));
        idx++;
      end
      for (int k = 0; k < 2; k++) begin
        tests++;
        if ({ov[k], oe[k]} !== {ev[k], ee[k]}) begin
          fails++;
          $display("FAIL gap_valid_eol w%0d got %b%b want %b%b", wid[k], ov[k], oe[k], ev[k], ee[k]);
        end
        if (known[k]) begin
          tests++;
          if ({ot[k], om[k], ob[k]} !== {et[k], em[k], eb[k]} || oc[k] != ec[k]) begin
            fails++;
            $display("FAIL gap_column w%0d got %02h %02h %02h c%0d want %02h %02h %02h c%0d",
                     wid[k], ot[k], om[k], ob[k], oc[k], et[k], em[k], eb[k], ec[k]);
          end
        end
      end
      if (a_valid) seq_gap.push_back({a_top, a_mid, a_bot, 6'd0, a_col});
    end
    tests++;
    if (seq_gap.size() != seq_cont.size()) begin
      fails++;
      $display("FAIL gap_seq_len got %0d want %0d", seq_gap.size(), seq_cont.size());
    end else begin
      for (int i = 0; i < seq_cont.size(); i++) begin
        tests++;
        if (seq_gap[i] !== seq_cont[i]) begin
          fails++;
          $display("FAIL gap_seq[%0d] got %08h want %08h", i, seq_gap[i], seq_cont[i]);
        end
      end
    end
  endtask

  task automatic test_sof_mid();
    int acc = 0;
    // Prime a frame up to (3,1); the next pixel (3,2) carries a new sof.
    for (int i = 0; i < 14; i++) cyc(1'b1, (i == 0), 8'($urandom));
    while (acc < 12) begin
      if (acc > 0 && $urandom_range(0, 2) == 0) begin
        cyc(1'b0, 1'b0, 8'h00);
      end else begin
        cyc(1'b1, (acc == 0), (acc == 0) ? 8'hAA : 8'($urandom));
        acc++;
        if (acc <= 8) begin
          tests++;
          if (a_valid !== 1'b0) begin
            fails++;
            $display("FAIL sof_suppress pixel %0d got v=%b want 0", acc, a_valid);
          end
        end
        if (acc == 9) begin
          tests++;
          if ({a_valid, a_top, a_col} !== {1'b1, 8'hAA, 2'd0}) begin
            fails++;
            $display("FAIL sof_first_col got v=%b top=%02h c%0d want 1 AA c0", a_valid, a_top, a_col);
          end
        end
      end
      for (int k = 0; k < 2; k++) begin
        tests++;
        if ({ov[k], oe[k]} !== {ev[k], ee[k]}) begin
          fails++;
          $display("FAIL sof_valid_eol w%0d got %b%b want %b%b", wid[k], ov[k], oe[k], ev[k], ee[k]);
        end
        if (known[k]) begin
          tests++;
          if ({ot[k], om[k], ob[k]} !== {et[k], em[k], eb[k]} || oc[k] != ec[k]) begin
            fails++;
            $display("FAIL sof_column w%0d got %02h %02h %02h c%0d want %02h %02h %02h c%0d",
                     wid[k], ot[k], om[k], ob[k], oc[k], et[k], em[k], eb[k], ec[k]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 13; i++) cyc(1'b1, (i == 0), 8'($urandom));
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_sof = 1'b0; in_pixel = 8'h55;
    model_reset();
    for (int j = 0; j < 2; j++) begin
      if (j == 1) begin
        @(posedge clk);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        tests++;
        if ({ov[k], oe[k], ot[k], om[k], ob[k]} !== 27'd0 || oc[k] != 0) begin
          fails++;
          $display("FAIL rst_mid_outputs w%0d got v=%b e=%b t=%02h m=%02h b=%02h c=%0d want all 0",
                   wid[k], ov[k], oe[k], ot[k], om[k], ob[k], oc[k]);
        end
      end
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b0, 8'($urandom));
      if (i < 8) begin
        tests++;
        if (a_valid !== 1'b0) begin
          fails++;
          $display("FAIL rst_suppress pixel %0d got v=%b want 0", i, a_valid);
        end
      end
      for (int k = 0; k < 2; k++) begin
        tests++;
        if ({ov[k], oe[k]} !== {ev[k], ee[k]}) begin
          fails++;
          $display("FAIL rst_valid_eol w%0d got %b%b want %b%b", wid[k], ov[k], oe[k], ev[k], ee[k]);
        end
        if (known[k]) begin
          tests++;
          if ({ot[k], om[k], ob[k]} !== {et[k], em[k], eb[k]} || oc[k] != ec[k]) begin
            fails++;
            $display("FAIL rst_column w%0d got %02h %02h %02h c%0d want %02h %02h %02h c%0d",
                     wid[k], ot[k], om[k], ob[k], oc[k], et[k], em[k], eb[k], ec[k]);
          end
        end
      end
    end
  endtask

  task automatic test_width2();
    int   first = -1;
    int   nv    = 0;
    logic [3:0] eol_seq = 4'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, (i == 0), 8'((i / 2) * 16 + (i % 2)));
      if (b_valid) begin
        if (first < 0) first = i;
        if (nv < 4) eol_seq = {eol_seq[2:0], b_eol};
        nv++;
      end
      tests++;
      if ({b_valid, b_eol} !== {ev[1], ee[1]}) begin
        fails++;
        $display("FAIL w2_valid_eol pixel %0d got %b%b want %b%b", i, b_valid, b_eol, ev[1], ee[1]);
      end
      if (known[1]) begin
        tests++;
        if ({b_top, b_mid, b_bot} !== {et[1], em[1], eb[1]} || int'(b_col) != ec[1]) begin
          fails++;
          $display("FAIL w2_column pixel %0d got %02h %02h %02h c%0d want %02h %02h %02h c%0d",
                   i, b_top, b_mid, b_bot, b_col, et[1], em[1], eb[1], ec[1]);
        end
      end
    end
    tests++;
    if (first != 4 || eol_seq !== 4'b0101 || nv != 6) begin
      fails++;
      $display("FAIL w2_pattern got first=%0d eol=%b n=%0d want first=4 eol=0101 n=6", first, eol_seq, nv);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_sof_mid();
    test_reset_mid();
    test_width2();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
